ili9341_init_seq: RTL
=====================

Name: ili9341_init_seq

Overview:
- Power-up sequencer that sits directly upstream of the ILI9341 pixel raster stage.
- Drives the panel hardware reset pulse, then serialises a fixed init command list: SWRESET, SLPOUT, COLMOD 16bpp, MADCTL, DISPON.
- On completion it asserts a level `start` to the raster stage and hands the shared cs/dc/din bus over to it.
- Uses the same on-wire format as the raster stage: `clk` is forwarded as SCL, and the bus changes on the falling edge.

Parameters:
- RST_LOW_CYC, 100, cycles `lcd_rst` is held low (10 µs at 10 MHz)
- RST_WAIT_CYC, 1200000, cycles after `lcd_rst` rises before the first byte (120 ms)
- SHORT_WAIT_CYC, 50000, delay selected by a DELAY entry with byte 0x00 (5 ms, after SWRESET)
- LONG_WAIT_CYC, 1200000, delay selected by a DELAY entry with byte 0x01 (120 ms, after SLPOUT)
- CNT_W, 21, delay counter width; must hold the largest wait minus 1

Ports:
- clk  in  1  system clock, also the panel SCL; all state is updated on negedge
- rst_n  in  1  asynchronous active-low reset
- ras_cs  in  1  raster-stage chip select
- ras_dc  in  1  raster-stage data/command select
- ras_din  in  1  raster-stage serial data
- start  out  1  level signal to raster stage; high once init is complete
- done  out  1  init complete (same value as `start`)
- lcd_rst  out  1  panel hardware reset, active low
- bl  out  1  backlight enable
- cs  out  1  panel chip select, active low
- dc  out  1  panel D/C: 0 = command, 1 = data
- din  out  1  panel serial data, MSB first

Behaviour:
- Async reset, while rst_n=0:
  - lcd_rst=0, cs=1, dc=0, din=0, bl=0, start=done=0.
  - State = HW_RST_LOW, counter=0, ROM index=0.
- Reset asserted mid-operation (including mid-byte):
  - Outputs take their reset values immediately.
  - After release the full sequence restarts from HW_RST_LOW; there is no resume.
- HW_RST_LOW:
  - lcd_rst=0 for exactly RST_LOW_CYC negedges after reset release.
  - Then lcd_rst=1, go to HW_RST_WAIT.
- HW_RST_WAIT:
  - Count RST_WAIT_CYC negedges, then go to FETCH.
- FETCH:
  - Read ROM[index] (10 bits: kind[1:0], byte[7:0]); this cycle always takes 1 cycle.
  - CMD or DATA → SETUP.
  - DELAY → WAIT; counter loaded with SHORT_WAIT_CYC-1 (byte 0x00) or LONG_WAIT_CYC-1 (byte 0x01).
  - END → DONE.
  - index increments on every FETCH except END.
- SETUP:
  - One cycle with cs=1; dc=0 for CMD, 1 for DATA; shift register loaded; bit index=7.
- SHIFT:
  - 8 cycles with cs=0; din = byte[bit index], bit index 7→0.
  - After bit 0 → FETCH.
  - cs returns high in the following FETCH/SETUP, matching the raster framing: setup cycle, then 8 low cycles.
- WAIT:
  - cs=1, din=0; count down to 0, then → FETCH.
- DONE:
  - Terminal state; only reset leaves it.
  - start=done=1, bl=1.
  - cs/dc/din are driven combinationally from ras_cs/ras_dc/ras_din.
- Bus ownership:
  - Before DONE, the ras_* inputs are ignored entirely.
  - There is no glitch at handover: in the DONE entry cycle the raster stage is still in its idle state with ras_cs=1.
- Init ROM contents:
  - 0 CMD 0x01
  - 1 DELAY 0x00
  - 2 CMD 0x11
  - 3 DELAY 0x01
  - 4 CMD 0x3A
  - 5 DATA 0x55
  - 6 CMD 0x36
  - 7 DATA 0x48
  - 8 CMD 0x29
  - 9 END
  - Out-of-range index decodes as END.
- Arithmetic:
  - Counters are unsigned.
  - A wait parameter of 0 is illegal; a value of 1 gives a single-cycle wait.

Decomposition:
- Shared package ili9341_pkg:
  - entry kind encodings: CMD=2'b00, DATA=2'b01, DELAY=2'b10, END=2'b11
  - opcode constants: SWRESET 0x01, SLPOUT 0x11, COLMOD 0x3A, MADCTL 0x36, DISPON 0x29, CASET 0x2A, PASET 0x2B, RAMWR 0x2C
  - init state enum
  - the raster stage also imports this package for its opcodes
- Sub-module ili9341_spi_byte_tx owns the SETUP/SHIFT framing:
  - inputs: load, byte, is_data
  - outputs: cs, dc, din, busy
  - reusable by the raster stage.
- The ROM is a case function inside ili9341_init_seq.

Test Plan:
- Byte sequence, with RST_LOW_CYC=4, RST_WAIT_CYC=10, SHORT_WAIT_CYC=6, LONG_WAIT_CYC=12:
  - Release rst_n; sample din on posedge while cs=0.
  - Required bytes: 0x01,0x11,0x3A,0x55,0x36,0x48,0x29 with dc=0,0,0,1,0,1,0.
  - Required: exactly 7 cs-low bursts of 8 cycles each.
- Reset and delay timing, same parameters:
  - lcd_rst low for exactly 4 negedges.
  - First cs fall occurs 10+2 cycles after lcd_rst rises (RST_WAIT_CYC plus FETCH and SETUP).
  - Gap between SWRESET bit 0 and SLPOUT's first cs-low is ≥ 6+2 cycles.
  - Gap after SLPOUT is ≥ 12+2 cycles.
- Handover:
  - After DONE, start=done=bl=1.
  - Toggle ras_cs/ras_dc/ras_din: cs/dc/din follow them.
  - Before DONE, toggling ras_* has no effect on the outputs.
- Reset mid-byte:
  - Assert rst_n=0 during bit 4 of 0x3A: cs=1, lcd_rst=0, start=0 asynchronously.
  - After release the sequence restarts, and the first byte seen is 0x01.
- Hold in DONE:
  - Run 1000 cycles after DONE: start stays 1, lcd_rst stays 1, no further ROM bytes are emitted.

Source files
------------

// File: rtl/ili9341_pkg.sv
// ili9341_pkg: definitions shared by the ILI9341 init sequencer and raster stage.
//   - init ROM entry kind encodings and the 10-bit entry packing helper
//   - panel opcodes used during init and by the raster stage
//   - state enumerations for the init sequencer and the byte transmitter
package ili9341_pkg;

   localparam logic [1:0] KIND_CMD   = 2'b00;
   localparam logic [1:0] KIND_DATA  = 2'b01;
   localparam logic [1:0] KIND_DELAY = 2'b10;
   localparam logic [1:0] KIND_END   = 2'b11;

   localparam logic [7:0] OP_SWRESET = 8'h01;
   localparam logic [7:0] OP_SLPOUT  = 8'h11;
   localparam logic [7:0] OP_COLMOD  = 8'h3A;
   localparam logic [7:0] OP_MADCTL  = 8'h36;
   localparam logic [7:0] OP_DISPON  = 8'h29;
   localparam logic [7:0] OP_CASET   = 8'h2A;
   localparam logic [7:0] OP_PASET   = 8'h2B;
   localparam logic [7:0] OP_RAMWR   = 8'h2C;

   typedef enum logic [2:0] {
      ST_HW_RST_LOW  = 3'd0,
      ST_HW_RST_WAIT = 3'd1,
      ST_FETCH       = 3'd2,
      ST_SETUP       = 3'd3,
      ST_SHIFT       = 3'd4,
      ST_WAIT        = 3'd5,
      ST_DONE        = 3'd6
   } init_state_t;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_SETUP = 2'd1,
      TX_SHIFT = 2'd2
   } tx_state_t;

   // Packs a ROM entry as {kind[1:0], byte[7:0]}.
   function automatic logic [9:0] make_entry(input logic [1:0] kind, input logic [7:0] value);
      return {kind, value};
   endfunction

endpackage

// File: rtl/ili9341_spi_byte_tx.sv
// ili9341_spi_byte_tx: one-byte panel SPI framer (setup cycle, then 8 low-cs bits).
// State changes on the falling edge of clk, which is forwarded to the panel as SCL.
// Ports:
//   clk, rst_n       clock (negedge active) and async active-low reset
//   load             start a frame (accepted only while idle)
//   data_byte        byte to send, MSB first
//   is_data          dc level for this frame: 0 = command, 1 = data
//   cs, dc, din      registered panel bus outputs
//   busy             high while the frame continues past the current cycle;
//                    low during the final bit so the owner can move on at that edge
module ili9341_spi_byte_tx
   import ili9341_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [7:0] data_byte,
   input  logic       is_data,
   output logic       cs,
   output logic       dc,
   output logic       din,
   output logic       busy
);

   tx_state_t  phase_r;
   logic [7:0] sh_r;
   logic [2:0] bit_r;
   logic       cs_r;
   logic       dc_r;
   logic       din_r;

   // Frame sequencer: idle -> setup (cs high, dc valid) -> 8 bits with cs low.
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_r <= TX_IDLE;
         sh_r    <= 8'h00;
         bit_r   <= 3'd0;
         cs_r    <= 1'b1;
         dc_r    <= 1'b0;
         din_r   <= 1'b0;
      end else begin
         case (phase_r)
            TX_IDLE: begin
               if (load) begin
                  phase_r <= TX_SETUP;
                  sh_r    <= data_byte;
                  bit_r   <= 3'd7;
                  dc_r    <= is_data;
               end else begin
                  phase_r <= TX_IDLE;
               end
               cs_r  <= 1'b1;
               din_r <= 1'b0;
            end
            TX_SETUP: begin
               phase_r <= TX_SHIFT;
               cs_r    <= 1'b0;
               din_r   <= sh_r[bit_r];
            end
            TX_SHIFT: begin
               if (bit_r == 3'd0) begin
                  phase_r <= TX_IDLE;
                  cs_r    <= 1'b1;
                  din_r   <= 1'b0;
               end else begin
                  bit_r <= bit_r - 3'd1;
                  din_r <= sh_r[bit_r - 3'd1];
               end
            end
            default: begin
               phase_r <= TX_IDLE;
               cs_r    <= 1'b1;
               din_r   <= 1'b0;
            end
         endcase
      end
   end

   assign cs   = cs_r;
   assign dc   = dc_r;
   assign din  = din_r;
   assign busy = (phase_r == TX_SETUP) || ((phase_r == TX_SHIFT) && (bit_r != 3'd0));

endmodule

// File: rtl/ili9341_init_seq.sv
// ili9341_init_seq: ILI9341 power-up sequencer. Pulses the panel reset, sends the
// fixed init list (SWRESET, SLPOUT, COLMOD 16bpp, MADCTL, DISPON) with its delays,
// then raises start and hands the cs/dc/din bus to the raster stage.
// Ports:
//   clk, rst_n              clock (also panel SCL, state on negedge), async active-low reset
//   ras_cs/ras_dc/ras_din   raster-stage bus, passed through only once init is done
//   start, done             init complete (level)
//   lcd_rst                 panel hardware reset, active low
//   bl                      backlight enable
//   cs, dc, din             panel bus
module ili9341_init_seq
   import ili9341_pkg::*;
#(
   parameter int unsigned RST_LOW_CYC    = 100,
   parameter int unsigned RST_WAIT_CYC   = 1200000,
   parameter int unsigned SHORT_WAIT_CYC = 50000,
   parameter int unsigned LONG_WAIT_CYC  = 1200000,
   parameter int          CNT_W          = 21
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ras_cs,
   input  logic ras_dc,
   input  logic ras_din,
   output logic start,
   output logic done,
   output logic lcd_rst,
   output logic bl,
   output logic cs,
   output logic dc,
   output logic din
);

   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_RST_LO = CNT_W'(RST_LOW_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_RST_WT = CNT_W'(RST_WAIT_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_SHORT  = CNT_W'(SHORT_WAIT_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_LONG   = CNT_W'(LONG_WAIT_CYC - 1);

   init_state_t      state_r;
   logic [CNT_W-1:0] cnt_r;
   logic [3:0]       idx_r;
   logic             lcd_rst_r;
   logic             done_r;
   logic             bl_r;
   logic [9:0]       entry_s;
   logic             load_s;
   logic             tx_cs;
   logic             tx_dc;
   logic             tx_din;
   logic             tx_busy;

   // Init command list; anything past the list reads as END.
   function automatic logic [9:0] rom_entry(input logic [3:0] idx);
      case (idx)
         4'd0:    rom_entry = make_entry(KIND_CMD,   OP_SWRESET);
         4'd1:    rom_entry = make_entry(KIND_DELAY, 8'h00);
         4'd2:    rom_entry = make_entry(KIND_CMD,   OP_SLPOUT);
         4'd3:    rom_entry = make_entry(KIND_DELAY, 8'h01);
         4'd4:    rom_entry = make_entry(KIND_CMD,   OP_COLMOD);
         4'd5:    rom_entry = make_entry(KIND_DATA,  8'h55);
         4'd6:    rom_entry = make_entry(KIND_CMD,   OP_MADCTL);
         4'd7:    rom_entry = make_entry(KIND_DATA,  8'h48);
         4'd8:    rom_entry = make_entry(KIND_CMD,   OP_DISPON);
         default: rom_entry = make_entry(KIND_END,   8'h00);
      endcase
   endfunction

   // ROM read and byte-transmit request for the current FETCH.
   always_comb begin
      entry_s = rom_entry(idx_r);
      if ((state_r == ST_FETCH) &&
          ((entry_s[9:8] == KIND_CMD) || (entry_s[9:8] == KIND_DATA))) begin
         load_s = 1'b1;
      end else begin
         load_s = 1'b0;
      end
   end

   // Main sequencer: reset pulse, reset wait, ROM walk, terminal DONE.
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_HW_RST_LOW;
         cnt_r     <= '0;
         idx_r     <= 4'd0;
         lcd_rst_r <= 1'b0;
         done_r    <= 1'b0;
         bl_r      <= 1'b0;
      end else begin
         case (state_r)
            ST_HW_RST_LOW: begin
               if (cnt_r == CNT_RST_LO) begin
                  cnt_r     <= '0;
                  lcd_rst_r <= 1'b1;
                  state_r   <= ST_HW_RST_WAIT;
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            ST_HW_RST_WAIT: begin
               if (cnt_r == CNT_RST_WT) begin
                  cnt_r   <= '0;
                  state_r <= ST_FETCH;
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            ST_FETCH: begin
               case (entry_s[9:8])
                  KIND_CMD, KIND_DATA: begin
                     idx_r   <= idx_r + 4'd1;
                     state_r <= ST_SETUP;
                  end
                  KIND_DELAY: begin
                     idx_r   <= idx_r + 4'd1;
                     cnt_r   <= (entry_s[7:0] == 8'h00) ? CNT_SHORT : CNT_LONG;
                     state_r <= ST_WAIT;
                  end
                  default: begin
                     done_r  <= 1'b1;
                     bl_r    <= 1'b1;
                     state_r <= ST_DONE;
                  end
               endcase
            end
            ST_SETUP: begin
               state_r <= ST_SHIFT;
            end
            ST_SHIFT: begin
               // busy drops during the last bit, so FETCH follows bit 0 directly.
               if (!tx_busy) begin
                  state_r <= ST_FETCH;
               end else begin
                  state_r <= ST_SHIFT;
               end
            end
            ST_WAIT: begin
               if (cnt_r == '0) begin
                  state_r <= ST_FETCH;
               end else begin
                  cnt_r <= cnt_r - CNT_ONE;
               end
            end
            ST_DONE: begin
               state_r <= ST_DONE;
            end
            default: begin
               state_r <= ST_HW_RST_LOW;
            end
         endcase
      end
   end

   ili9341_spi_byte_tx u_tx (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load_s),
      .data_byte (entry_s[7:0]),
      .is_data   (entry_s[9:8] == KIND_DATA),
      .cs        (tx_cs),
      .dc        (tx_dc),
      .din       (tx_din),
      .busy      (tx_busy)
   );

   // Once done, the raster stage owns the bus directly (no added latency).
   assign cs      = done_r ? ras_cs  : tx_cs;
   assign dc      = done_r ? ras_dc  : tx_dc;
   assign din     = done_r ? ras_din : tx_din;
   assign start   = done_r;
   assign done    = done_r;
   assign bl      = bl_r;
   assign lcd_rst = lcd_rst_r;

endmodule
